// File: rtl/pong_pkg.sv
// Shared types and default playfield geometry for the pong paddle logic.
package pong_pkg;

    // Paddle AI behaviour states; encoding 3 is never produced.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_RETURN = 2'd2
    } state_e;

    localparam int MAX_V_DEF  = 240;
    localparam int MIN_V_DEF  = 0;
    localparam int HEIGTH_DEF = 20;

    // Behaviour is chosen purely from the current inputs each clock.
    function automatic state_e next_state(input logic enable, input logic approaching);
        if (!enable) begin
            return ST_IDLE;
        end else if (approaching) begin
            return ST_TRACK;
        end
        return ST_RETURN;
    endfunction

endpackage

// File: rtl/rate_divider.sv
// Decision-rate counter: counts 0..REACT_CYCLES-1, wraps, and can be held at 0.
module rate_divider #(
    parameter int REACT_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(REACT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(REACT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: hold at zero while cleared, otherwise wrap at LAST.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_q == LAST) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(1);
        end
    end

    // Counter register with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = (count_q == LAST);

endmodule

// File: rtl/paddle_ai.sv
// Computer-controlled paddle: follows the ball while it approaches, otherwise
// drifts back to the home position, issuing at most one move per decision period.
module paddle_ai
    import pong_pkg::*;
#(
    parameter int HEIGTH       = HEIGTH_DEF,
    parameter int MAX_V        = MAX_V_DEF,
    parameter int MIN_V        = MIN_V_DEF,
    parameter int START_V      = (MAX_V - MIN_V) / 2,
    parameter int REACT_CYCLES = 4,
    parameter int DEADBAND     = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       approaching,
    input  logic [8:0] ball_y,
    input  logic [8:0] paddle_y,
    output logic       up,
    output logic       down,
    output logic [1:0] state
);

    localparam logic [9:0]        HALF_H  = 10'(HEIGTH / 2);
    localparam logic [9:0]        HEIGHT10 = 10'(HEIGTH);
    localparam logic [9:0]        MAX_V10 = 10'(MAX_V);
    localparam logic [9:0]        MIN_V10 = 10'(MIN_V);
    localparam logic [9:0]        HOME_V  = 10'(START_V);
    localparam logic signed [10:0] DB_POS = 11'(DEADBAND);
    localparam logic signed [10:0] DB_NEG = -DB_POS;

    state_e state_q;
    state_e state_d;
    logic   up_q;
    logic   up_d;
    logic   down_q;
    logic   down_d;

    logic              clear;
    logic              div_tick;
    logic              decide;
    logic [9:0]        target;
    logic [9:0]        centre;
    logic [9:0]        top;
    logic signed [10:0] err;

    rate_divider #(
        .REACT_CYCLES(REACT_CYCLES)
    ) u_rate_divider (
        .clock(clock),
        .reset(reset),
        .clear(clear),
        .tick (div_tick)
    );

    // Next state, move decision and registered move requests.
    always_comb begin
        state_d = next_state(enable, approaching);
        clear   = (state_q == ST_IDLE) || (state_d != state_q);
        // A decision only counts in an active state, and never once enable has dropped.
        decide  = div_tick && enable && ((state_q == ST_TRACK) || (state_q == ST_RETURN));

        case (state_q)
            ST_TRACK:  target = {1'b0, ball_y};
            ST_RETURN: target = HOME_V;
            default:   target = HOME_V;
        endcase

        centre = {1'b0, paddle_y} + HALF_H;
        top    = {1'b0, paddle_y} + HEIGHT10;
        err    = $signed({1'b0, target}) - $signed({1'b0, centre});

        // Opposite error signs keep up and down mutually exclusive.
        up_d   = decide && (err > DB_POS) && (top < MAX_V10);
        down_d = decide && (err < DB_NEG) && ({1'b0, paddle_y} > MIN_V10);
    end

    // State and output registers, cleared immediately by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            up_q    <= up_d;
            down_q  <= down_d;
        end
    end

    assign up    = up_q;
    assign down  = down_q;
    assign state = state_q;

endmodule

// File: doc/paddle_ai.md
PADDLE_AI -- requirements
Module: paddle_ai

Interface
REQ-001 The block SHALL have parameter HEIGTH, default 20, meaning paddle height in pixels.
REQ-002 The block SHALL have parameter MAX_V, default 240, meaning the maximum vertical position.
REQ-003 The block SHALL have parameter MIN_V, default 0, meaning the minimum vertical position.
REQ-004 The block SHALL have parameter START_V, default (MAX_V-MIN_V)/2, meaning the home centre position.
REQ-005 The block SHALL have parameter REACT_CYCLES, default 4, meaning clocks per movement decision (>=2).
REQ-006 The block SHALL have parameter DEADBAND, default 2, meaning the tolerated |error| in pixels before moving.
REQ-007 The block SHALL have port clock, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-008 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-009 The block SHALL have port enable, input, 1 bit: AI control active.
REQ-010 The block SHALL have port approaching, input, 1 bit: ball horizontal direction is toward this paddle.
REQ-011 The block SHALL have port ball_y, input, 9 bits: ball vertical position.
REQ-012 The block SHALL have port paddle_y, input, 9 bits: current paddle bottom position, fed back from the paddle.
REQ-013 The block SHALL have port up, output, 1 bit: registered one-cycle request to increment paddle_y.
REQ-014 The block SHALL have port down, output, 1 bit: registered one-cycle request to decrement paddle_y.
REQ-015 The block SHALL have port state, output, 2 bits: current FSM state, for debug.

Function
REQ-016 The FSM SHALL have states IDLE=0, TRACK=1 and RETURN=2; encoding 3 is unused and SHALL go to IDLE.
REQ-017 State transitions SHALL occur every clock: enable=0 -> IDLE; enable=1 with approaching=1 -> TRACK; enable=1 with approaching=0 -> RETURN.
REQ-018 The decision counter SHALL count 0..REACT_CYCLES-1 and wrap; it SHALL be held at 0 in IDLE and on any state change.
REQ-019 A decision tick SHALL occur when the counter equals REACT_CYCLES-1 in TRACK or RETURN.
REQ-020 The target SHALL be ball_y in TRACK and START_V in RETURN; centre = paddle_y + HEIGTH/2, computed in 10 bits.
REQ-021 Error SHALL be computed as signed 11-bit target minus centre, with no truncation.
REQ-022 On a tick with error > DEADBAND and paddle_y+HEIGTH < MAX_V, up SHALL be 1 in the next cycle only.
REQ-023 On a tick with error < -DEADBAND and paddle_y > MIN_V, down SHALL be 1 in the next cycle only.
REQ-024 Otherwise, including |error| <= DEADBAND, a blocked boundary, and every non-tick cycle, up and down SHALL be 0 in the next cycle.
REQ-025 up and down SHALL never be 1 simultaneously.
REQ-026 The pulse rate SHALL be at most one per REACT_CYCLES clocks.
REQ-027 If enable falls, up and down SHALL be 0 from the next cycle.

Reset
REQ-028 While reset=0, up=0, down=0, state=IDLE and counter=0 SHALL hold immediately, without waiting for clock.
REQ-029 After reset release, the first tick SHALL occur no earlier than REACT_CYCLES clocks after entering TRACK or RETURN.

Structure
REQ-030 Package pong_pkg SHALL hold the state enum typedef and the default geometry constants (MAX_V, MIN_V, HEIGTH).
REQ-031 The counter SHALL be one sub-module, rate_divider (inputs clock, reset, clear; output tick).
REQ-032 The error/compare logic SHALL be combinational inside paddle_ai, and outputs SHALL be registered.

Verification (defaults unless stated)
REQ-033 Assert reset=0 mid-pulse -> up=0, down=0, state=0 immediately.
REQ-034 enable=1, approaching=1, paddle_y=100, ball_y=150 -> state=1; up pulses 1 cycle per 4 clocks; down=0 throughout.
REQ-035 paddle_y=100, ball_y=111 (error=+1) -> no pulses over 40 clocks; ball_y=113 -> up pulses resume.
REQ-036 paddle_y=220, ball_y=239 -> no up pulse; paddle_y=0, ball_y=0 -> no down pulse.
REQ-037 approaching=0, paddle_y=50 -> state=2, up pulses; paddle_y=130 -> down pulses; paddle_y=110 -> none.
REQ-038 Drop enable at count 2, re-raise after 3 clocks -> outputs 0 next cycle; first pulse 4 clocks after re-enable.
